// File: rtl/id_field_extract_pkg.sv
// Shared constants for the decode-stage field extractor.
//   DEF_REG_ADDR_W / DEF_IMM_W / DEF_DATA_W : default widths for the block parameters
//   DST_RT / DST_RD                         : reg_dst encodings (destination = rt or rd)
//   EXT_SIGN / EXT_ZERO                     : zero_ext encodings (sign- or zero-extend)
package id_field_extract_pkg;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_IMM_W      = 16;
    localparam int DEF_DATA_W     = 32;

    localparam logic DST_RT = 1'b0;
    localparam logic DST_RD = 1'b1;

    localparam logic EXT_SIGN = 1'b0;
    localparam logic EXT_ZERO = 1'b1;

endpackage

// File: rtl/id_field_extract_imm_extender.sv
// imm_extender: purely combinational immediate widener.
//   imm_in      [IMM_W-1:0]  raw instruction immediate
//   zero_ext                 EXT_ZERO = pad with zeros, EXT_SIGN = replicate the MSB
//   imm_ext_out [DATA_W-1:0] extended immediate (DATA_W must exceed IMM_W)
module imm_extender
    import id_field_extract_pkg::*;
#(
    parameter int IMM_W  = DEF_IMM_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [IMM_W-1:0]  imm_in,
    input  logic              zero_ext,
    output logic [DATA_W-1:0] imm_ext_out
);

    logic signed [IMM_W-1:0]  imm_s;
    logic signed [DATA_W-1:0] imm_sext;
    logic        [DATA_W-1:0] imm_zext;

    assign imm_s    = imm_in;
    assign imm_sext = {{(DATA_W-IMM_W){imm_s[IMM_W-1]}}, imm_s};
    assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm_in};

    always_comb begin
        imm_ext_out = imm_sext;
        if (zero_ext == EXT_ZERO) begin
            imm_ext_out = imm_zext;
        end
    end

endmodule

// File: rtl/id_field_extract.sv
// id_field_extract: decode-stage field extractor feeding the ID/EX boundary.
// Selects the destination register (rt or rd), widens the immediate and
// registers everything for one cycle of latency; a stall holds all fields.
//   clk, reset (async, active-high)
//   stall_flag_in   1 = hold outputs, 0 = capture new fields
//   reg_dst         DST_RT selects rt_addr, DST_RD selects rd_addr
//   rt_addr/rd_addr register address fields
//   imm_in          raw immediate, zero_ext picks zero- or sign-extension
//   wr_addr_out     registered destination register
//   imm_ext_out     registered extended immediate
//   imm_shl2_out    registered extended immediate << 2 (word offset)
//   imm_raw_out     registered raw immediate
//   stall_flag_out  stall_flag_in delayed one cycle (not held by stall)
module id_field_extract
    import id_field_extract_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int IMM_W      = DEF_IMM_W,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_flag_in,
    input  logic                  reg_dst,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic [IMM_W-1:0]      imm_in,
    input  logic                  zero_ext,
    output logic [REG_ADDR_W-1:0] wr_addr_out,
    output logic [DATA_W-1:0]     imm_ext_out,
    output logic [DATA_W-1:0]     imm_shl2_out,
    output logic [IMM_W-1:0]      imm_raw_out,
    output logic                  stall_flag_out
);

    logic [REG_ADDR_W-1:0] wr_addr_p0;
    logic [DATA_W-1:0]     imm_ext_p0;
    logic [DATA_W-1:0]     imm_shl2_p0;

    // Stage p0: combinational field decode from the instruction register
    imm_extender #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_imm_extender (
        .imm_in      (imm_in),
        .zero_ext    (zero_ext),
        .imm_ext_out (imm_ext_p0)
    );

    assign wr_addr_p0  = (reg_dst == DST_RD) ? rd_addr : rt_addr;
    // Word offset: the two bits shifted out of the top are dropped.
    assign imm_shl2_p0 = {imm_ext_p0[DATA_W-3:0], 2'b00};

    // Stage p0 -> p1: ID/EX register, held while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr_out    <= '0;
            imm_ext_out    <= '0;
            imm_shl2_out   <= '0;
            imm_raw_out    <= '0;
            stall_flag_out <= 1'b0;
        end else begin
            stall_flag_out <= stall_flag_in;
            if (!stall_flag_in) begin
                wr_addr_out  <= wr_addr_p0;
                imm_ext_out  <= imm_ext_p0;
                imm_shl2_out <= imm_shl2_p0;
                imm_raw_out  <= imm_in;
            end
        end
    end

endmodule

// File: tb/tb_id_field_extract.sv
module tb_id_field_extract;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_flag_in;
    logic        reg_dst;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [15:0] imm_in;
    logic        zero_ext;
    logic [4:0]  wr_addr_out;
    logic [31:0] imm_ext_out;
    logic [31:0] imm_shl2_out;
    logic [15:0] imm_raw_out;
    logic        stall_flag_out;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [4:0]  m_wr;
    logic [31:0] m_ext;
    logic [31:0] m_shl;
    logic [15:0] m_raw;
    logic        m_stall;

    id_field_extract #(
        .REG_ADDR_W (5),
        .IMM_W      (16),
        .DATA_W     (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_flag_in  (stall_flag_in),
        .reg_dst        (reg_dst),
        .rt_addr        (rt_addr),
        .rd_addr        (rd_addr),
        .imm_in         (imm_in),
        .zero_ext       (zero_ext),
        .wr_addr_out    (wr_addr_out),
        .imm_ext_out    (imm_ext_out),
        .imm_shl2_out   (imm_shl2_out),
        .imm_raw_out    (imm_raw_out),
        .stall_flag_out (stall_flag_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] extend(input logic [15:0] v, input logic z);
        int r;
        if (z) r = int'(v);
        else   r = int'($signed(v));
        return r;
    endfunction

    // Behavioural model: what the ID/EX register must hold.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_wr = '0; m_ext = '0; m_shl = '0; m_raw = '0; m_stall = 1'b0;
        end else begin
            m_stall = stall_flag_in;
            if (!stall_flag_in) begin
                m_wr  = reg_dst ? rd_addr : rt_addr;
                m_ext = extend(imm_in, zero_ext);
                m_shl = m_ext * 32'd4;
                m_raw = imm_in;
            end
        end
    end

    // Compare process: every falling edge, DUT against model.
    always @(negedge clk) begin
        checks++;
        if (wr_addr_out !== m_wr || imm_ext_out !== m_ext || imm_shl2_out !== m_shl ||
            imm_raw_out !== m_raw || stall_flag_out !== m_stall) begin
            errors++;
            $display("FAIL model_cmp t=%0t dut wr=%0d ext=%h shl=%h raw=%h st=%b expected wr=%0d ext=%h shl=%h raw=%h st=%b",
                     $time, wr_addr_out, imm_ext_out, imm_shl2_out, imm_raw_out, stall_flag_out,
                     m_wr, m_ext, m_shl, m_raw, m_stall);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rdst, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic z);
        @(negedge clk);
        stall_flag_in = st; reg_dst = rdst; rt_addr = rt; rd_addr = rd;
        imm_in = imm; zero_ext = z;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall_flag_in = 1'b0; reg_dst = 1'b0; rt_addr = '0; rd_addr = '0;
        imm_in = '0; zero_ext = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ext", imm_ext_out, 32'h0);
        chk("reset_wr", {27'd0, wr_addr_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // destination select and sign extension
        drive(1'b0, 1'b0, 5'd8, 5'd17, 16'h8000, 1'b0);
        chk("dst_rt", {27'd0, wr_addr_out}, 32'd8);
        chk("sext_8000", imm_ext_out, 32'hFFFF8000);
        chk("shl_8000", imm_shl2_out, 32'hFFFE0000);
        chk("raw_8000", {16'd0, imm_raw_out}, 32'h8000);
        chk("model_8000", m_ext, 32'hFFFF8000);
        drive(1'b0, 1'b1, 5'd8, 5'd17, 16'h7FFF, 1'b0);
        chk("dst_rd", {27'd0, wr_addr_out}, 32'd17);
        chk("sext_7fff", imm_ext_out, 32'h00007FFF);
        chk("shl_7fff", imm_shl2_out, 32'h0001FFFC);
        drive(1'b0, 1'b0, 5'd0, 5'd17, 16'hFFFF, 1'b1);
        chk("zext_ffff", imm_ext_out, 32'h0000FFFF);
        chk("zshl_ffff", imm_shl2_out, 32'h0003FFFC);
        chk("wr_zero", {27'd0, wr_addr_out}, 32'd0);
        drive(1'b0, 1'b0, 5'd0, 5'd17, 16'hFFFF, 1'b0);
        chk("sext_ffff", imm_ext_out, 32'hFFFFFFFF);
        chk("sshl_ffff", imm_shl2_out, 32'hFFFFFFFC);
        chk("model_shl_ffff", m_shl, 32'hFFFFFFFC);

        // stall hold
        drive(1'b0, 1'b1, 5'd0, 5'd3, 16'h0010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 5'd0, 5'd31, 16'hABCD, 1'b0);
            chk("stall_ext", imm_ext_out, 32'h00000010);
            chk("stall_wr", {27'd0, wr_addr_out}, 32'd3);
            chk("stall_out", {31'd0, stall_flag_out}, 32'd1);
        end
        drive(1'b0, 1'b1, 5'd0, 5'd31, 16'hABCD, 1'b0);
        chk("release_ext", imm_ext_out, 32'hFFFFABCD);
        chk("release_wr", {27'd0, wr_addr_out}, 32'd31);
        chk("release_stall_out", {31'd0, stall_flag_out}, 32'd0);

        // asynchronous reset mid-cycle, during a stall
        @(negedge clk);
        stall_flag_in = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_ext", imm_ext_out, 32'h0);
        chk("async_rst_shl", imm_shl2_out, 32'h0);
        chk("async_rst_wr", {27'd0, wr_addr_out}, 32'd0);
        chk("async_rst_raw", {16'd0, imm_raw_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_stall_ext", imm_ext_out, 32'h0);
        chk("rst_stall_out", {31'd0, stall_flag_out}, 32'd1);
        drive(1'b0, 1'b0, 5'd9, 5'd31, 16'h1234, 1'b1);
        chk("post_rst_ext", imm_ext_out, 32'h00001234);
        chk("post_rst_wr", {27'd0, wr_addr_out}, 32'd9);

        // randomized traffic with occasional mid-cycle reset pulses
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            stall_flag_in = ($urandom_range(0, 3) == 0);
            reg_dst  = 1'($urandom);
            rt_addr  = 5'($urandom);
            rd_addr  = 5'($urandom);
            imm_in   = 16'($urandom);
            zero_ext = 1'($urandom);
            if (reset) begin
                #2 reset = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                #2 reset = 1'b1;
            end
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_field_extract.md
Name: id_field_extract

Overview:
- Decode-stage field extractor between the instruction register and the ID/EX boundary.
- Selects the destination register address (rt vs rd) and produces the sign- or zero-extended 16-bit immediate, its word-offset form (<<2) and the raw field.
- All outputs are registered and hold their values while the stage is stalled.

Parameters:
- REG_ADDR_W, 5, register-address width.
- IMM_W, 16, immediate field width.
- DATA_W, 32, extended-immediate width; must be greater than IMM_W.

Ports:
- clk  input  1  single clock, rising-edge active.
- reset  input  1  asynchronous, active-high; clears all state.
- stall_flag_in  input  1  1 = hold all outputs; 0 = capture new fields.
- reg_dst  input  1  destination select: 0 = rt_addr, 1 = rd_addr.
- rt_addr  input  REG_ADDR_W  instruction rt field.
- rd_addr  input  REG_ADDR_W  instruction rd field.
- imm_in  input  IMM_W  instruction immediate field.
- zero_ext  input  1  1 = zero-extend, 0 = sign-extend.
- wr_addr_out  output  REG_ADDR_W  selected destination register.
- imm_ext_out  output  DATA_W  extended immediate.
- imm_shl2_out  output  DATA_W  imm_ext_out shifted left by 2, upper bits discarded, low 2 bits 0.
- imm_raw_out  output  IMM_W  unextended immediate.
- stall_flag_out  output  1  registered copy of stall_flag_in.

Behaviour:
- Reset (asynchronous, active-high):
  - wr_addr_out, imm_ext_out, imm_shl2_out, imm_raw_out = 0.
  - stall_flag_out = 0.
  - Reset takes effect immediately, independent of clk.
  - While reset is high, every clock edge is ignored.
- On each rising clk with reset low and stall_flag_in = 0:
  - wr_addr_out <= reg_dst ? rd_addr : rt_addr.
  - imm_ext_out <= zero_ext ? {zeros, imm_in} : {replicate imm_in[IMM_W-1] to DATA_W-IMM_W bits, imm_in}.
  - imm_shl2_out <= (extended value << 2), truncated to DATA_W.
  - imm_raw_out <= imm_in.
- On each rising clk with reset low and stall_flag_in = 1:
  - wr_addr_out, imm_ext_out, imm_shl2_out and imm_raw_out keep their previous values.
  - Input changes during the stall are not captured.
- stall_flag_out <= stall_flag_in on every rising clk, stalled or not; reset value 0.
- Latency: exactly one cycle from inputs to outputs. There is no combinational path from inputs to outputs.
- Stall release: the first rising edge with stall_flag_in = 0 captures the inputs present at that edge. No bubble is inserted and no extra delay is added.
- Reset deasserting in the same cycle as a stall: the outputs remain 0 until the first unstalled edge.
- Boundary values:
  - imm_in = 16'h7FFF sign-extends to 32'h00007FFF.
  - imm_in = 16'h8000 sign-extends to 32'hFFFF8000.
  - imm_in = 16'hFFFF sign-extends to 32'hFFFFFFFF; the shifted form is 32'hFFFFFFFC.
  - Register address 0 is passed through like any other address. Register-0 semantics are handled downstream.

Decomposition:
- Shared package holds:
  - REG_ADDR_W, IMM_W and DATA_W default constants.
  - The reg_dst encoding constants DST_RT = 0 and DST_RD = 1.
  - The extension-mode constants EXT_SIGN = 0 and EXT_ZERO = 1.
- One natural sub-module: imm_extender. It is purely combinational: IMM_W-bit input plus zero_ext in, DATA_W-bit extended value out.
- The destination mux and the output registers stay inline in id_field_extract.

Test Plan:
- Reset: assert reset mid-cycle after outputs hold nonzero values -> all outputs 0 immediately, before the next clk edge.
- Destination select: rt_addr=5'd8, rd_addr=5'd17. reg_dst=0, then 1 on consecutive cycles -> wr_addr_out = 8, then 17, each one cycle after the input.
- Sign extension: imm_in=16'h8000, zero_ext=0 -> imm_ext_out = 32'hFFFF8000, imm_shl2_out = 32'hFFFE0000, imm_raw_out = 16'h8000.
  - Then imm_in=16'h7FFF -> imm_ext_out = 32'h00007FFF, imm_shl2_out = 32'h0001FFFC.
- Zero extension: imm_in=16'hFFFF, zero_ext=1 -> imm_ext_out = 32'h0000FFFF, imm_shl2_out = 32'h0003FFFC.
  - With zero_ext=0 -> imm_ext_out = 32'hFFFFFFFF, imm_shl2_out = 32'hFFFFFFFC.
- Stall hold: capture imm_in=16'h0010, reg_dst=1, rd_addr=5'd3. Raise stall_flag_in for 3 cycles while driving imm_in=16'hABCD and rd_addr=5'd31:
  - outputs stay 32'h00000010 / 3;
  - stall_flag_out follows stall_flag_in one cycle late;
  - on release, the next edge captures 32'hFFFFABCD / 31.
- Reset during stall: stall_flag_in=1 and reset pulsed -> outputs 0, and they stay 0 until the first unstalled edge.
